txuart: RTL and testbench

Serial UART transmitter that pairs with `rxuart` and shares its 31-bit setup word format. It accepts one character per write handshake and frames it with a start bit, 5–8 data bits (LSB first), optional parity and one or two stop bits. It can hold the line in a break condition, and can gate each character on CTS. It sits between the bus-side TX FIFO/register logic and the `o_uart_tx` pad.

---
 rtl/txuart.sv | 214 +++++++++++++++++++++
 tb/tb_txuart.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txuart.sv
// txuart: serial UART transmitter. It uses the same 31-bit setup word as rxuart.
// Each frame is a start bit, 5-8 data bits (LSB first), an optional parity bit
// and one or two stop bits. The line can also be held in a break condition.
// Optional build macro: TXUART_HWFLOW_EN gates acceptance of a character on CTS.
//
// Ports:
//   i_clk      clock
//   i_reset_n  synchronous active-low reset
//   i_setup    setup word: [29:28] data bits (00=8..11=5), [27] two stop bits,
//              [26] parity enable, [25] fixed parity, [24] even / fixed value,
//              [23:0] clocks per baud, [30] ignored
//   i_wr       write strobe
//   i_data     character; bits above the configured width are ignored
//   i_break    request a line break
//   i_cts_n    clear-to-send, active-low (used only with TXUART_HWFLOW_EN)
//   o_uart_tx  serial line, idle = 1
//   o_busy     high when a write would not be accepted
module txuart #(
    parameter logic [30:0] INITIAL_SETUP = 31'd868
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [30:0] i_setup,
    input  logic        i_wr,
    input  logic [7:0]  i_data,
    input  logic        i_break,
    input  logic        i_cts_n,
    output logic        o_uart_tx,
    output logic        o_busy
);
    localparam int unsigned BAUD_W     = 24;
    localparam int unsigned BITS_W     = 4;
    localparam int unsigned SETUP_W    = 30;
    localparam int unsigned GUARD_BITS = 16;

    typedef enum logic [2:0] {
        S_RESET_GUARD,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_SECOND_STOP,
        S_BREAK
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BITS_W-1:0]   bits_q, bits_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_q, par_d;
    logic [SETUP_W-1:0]  setup_q, setup_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;

    logic                baud_end;
    logic                frame_end;
    logic [BAUD_W-1:0]   bit_load;
    logic [BITS_W-1:0]   data_last;
    logic [7:0]          wr_masked;
    logic                cts_ok;
    logic                flow_hold;
    logic                unused_bits;

`ifdef TXUART_HWFLOW_EN
    assign cts_ok      = ~i_cts_n;
    assign flow_hold   = i_cts_n;
    assign unused_bits = i_setup[30];
`else
    assign cts_ok      = 1'b1;
    assign flow_hold   = 1'b0;
    assign unused_bits = ^{i_setup[30], i_cts_n};
`endif

    assign baud_end  = (baud_q == '0);
    assign bit_load  = setup_q[23:0] - 24'd1;
    assign data_last = 4'd7 - {2'b00, setup_q[29:28]};
    assign wr_masked = i_data & (8'hFF >> i_setup[29:28]);

    // Next-state, line bit and busy for the coming cycle
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q - 24'd1;
        bits_d    = bits_q;
        shift_d   = shift_q;
        par_d     = par_q;
        setup_d   = setup_q;
        tx_d      = tx_q;
        frame_end = 1'b0;

        case (state_q)
            S_RESET_GUARD: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    baud_d = bit_load;
                    if (bits_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        bits_d = bits_q - 4'd1;
                    end
                end
            end
            S_IDLE: begin
                frame_end = 1'b1;
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    baud_d  = bit_load;
                    bits_d  = data_last;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = bit_load;
                    if (bits_q != '0) begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bits_d  = bits_q - 4'd1;
                    end else if (setup_q[26]) begin
                        state_d = S_PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    baud_d  = bit_load;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (setup_q[27]) begin
                        state_d = S_SECOND_STOP;
                        baud_d  = bit_load;
                        tx_d    = 1'b1;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
            end
            S_SECOND_STOP: begin
                if (baud_end) begin
                    frame_end = 1'b1;
                end
            end
            S_BREAK: begin
                tx_d = 1'b0;
                if (!i_break) begin
                    // Guard period lets the far receiver re-synchronise
                    state_d = S_RESET_GUARD;
                    baud_d  = bit_load;
                    bits_d  = BITS_W'(GUARD_BITS - 1);
                    tx_d    = 1'b1;
                end
            end
        endcase

        // Idle or last stop bit: break wins over a write, a write chains back-to-back
        if (frame_end) begin
            if (i_break) begin
                state_d = S_BREAK;
                setup_d = i_setup[29:0];
                tx_d    = 1'b0;
            end else if (i_wr && cts_ok) begin
                state_d = S_START;
                setup_d = i_setup[29:0];
                baud_d  = i_setup[23:0] - 24'd1;
                shift_d = wr_masked;
                par_d   = i_setup[25] ? i_setup[24]
                                      : (i_setup[24] ? ^wr_masked : ~^wr_masked);
                tx_d    = 1'b0;
            end else begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE) || flow_hold;
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= S_RESET_GUARD;
            baud_q  <= INITIAL_SETUP[23:0] - 24'd1;
            bits_q  <= BITS_W'(GUARD_BITS - 1);
            shift_q <= '0;
            par_q   <= 1'b0;
            setup_q <= INITIAL_SETUP[29:0];
            tx_q    <= 1'b1;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            setup_q <= setup_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign o_uart_tx = tx_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_txuart.sv
// tb_txuart: randomized and directed self-checking bench for txuart.
// The reference model builds each frame as a list of line bits from the setup
// word and character, and every bit is expected for exactly B clock cycles.
module tb_txuart;
    logic        clk;
    logic        i_reset_n;
    logic [30:0] i_setup;
    logic        i_wr;
    logic [7:0]  i_data;
    logic        i_break;
    logic        i_cts_n;
    logic        o_uart_tx;
    logic        o_busy;

    int n_vec = 0;
    int n_err = 0;
    bit exp_q[$];

    txuart #(.INITIAL_SETUP(31'd8)) dut (
        .i_clk     (clk),
        .i_reset_n (i_reset_n),
        .i_setup   (i_setup),
        .i_wr      (i_wr),
        .i_data    (i_data),
        .i_break   (i_break),
        .i_cts_n   (i_cts_n),
        .o_uart_tx (o_uart_tx),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line bits of one frame, each lasting B cycles
    function automatic void build_frame(input logic [30:0] s, input logic [7:0] d);
        int nbits;
        int ones;
        exp_q.delete();
        nbits = 8 - int'(s[29:28]);
        ones  = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (s[26]) begin
            if (s[25])      exp_q.push_back(s[24]);
            else if (s[24]) exp_q.push_back(bit'(ones % 2));
            else            exp_q.push_back(!bit'(ones % 2));
        end
        exp_q.push_back(1'b1);
        if (s[27]) exp_q.push_back(1'b1);
    endfunction

    function automatic logic [30:0] rand_setup();
        logic [30:0] r;
        r = 31'($urandom);
        r[23:0] = 24'($urandom_range(2, 6));
        return r;
    endfunction

    task automatic check_idle();
        check("idle_tx", o_uart_tx, 1'b1);
        check("idle_busy", o_busy, 1'b0);
    endtask

    // Writes are presented (and must be ignored) except in the last guard cycle
    task automatic check_guard(input int b);
        for (int i = 0; i < 16 * b; i++) begin
            check("guard_tx", o_uart_tx, 1'b1);
            check("guard_busy", o_busy, 1'b1);
            i_wr   = (i == 16 * b - 1) ? 1'b0 : 1'($urandom);
            i_data = 8'($urandom);
            tick();
        end
        i_wr = 1'b0;
    endtask

    task automatic start_write(input logic [30:0] s, input logic [7:0] d);
        i_setup = s;
        i_data  = d;
        i_wr    = 1'b1;
        i_break = 1'b0;
        i_cts_n = 1'b0;
        tick();
        i_wr = 1'b0;
    endtask

    // Checks a whole frame from its start bit; with hold=0 the other inputs are
    // scrambled mid-frame and quietened on the final cycle.
    task automatic expect_frame(input logic [30:0] s, input logic [7:0] d, input bit hold);
        int b;
        int nb;
        bit last;
        build_frame(s, d);
        b  = int'(s[23:0]);
        nb = exp_q.size();
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < b; k++) begin
                check("frame_tx", o_uart_tx, exp_q[i]);
                check("frame_busy", o_busy, 1'b1);
                if (!hold) begin
                    last    = (i == nb - 1) && (k == b - 1);
                    i_setup = 31'($urandom);
                    i_data  = 8'($urandom);
                    i_wr    = last ? 1'b0 : 1'($urandom);
                    i_cts_n = last ? 1'b0 : 1'($urandom);
                end
                tick();
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [30:0] s;
        logic [30:0] s2;
        logic [7:0]  d;
        logic [7:0]  d2;

        i_reset_n = 1'b0;
        i_setup   = 31'd8;
        i_wr      = 1'b0;
        i_data    = 8'h00;
        i_break   = 1'b0;
        i_cts_n   = 1'b0;

        // Reset and power-up guard (INITIAL_SETUP = 8N1, B=8)
        tick();
        tick();
        check("rst_tx", o_uart_tx, 1'b1);
        check("rst_busy", o_busy, 1'b1);
        i_reset_n = 1'b1;
        check_guard(8);
        check_idle();

        // 8N1, B=8, 0x55
        s = 31'd8;
        start_write(s, 8'h55);
        expect_frame(s, 8'h55, 1'b0);
        check_idle();

        // 7E2, B=4, 0xC3 sent as 0x43
        s = 31'h1D00_0004;
        start_write(s, 8'hC3);
        expect_frame(s, 8'hC3, 1'b0);
        check_idle();

        // 5-bit odd parity, then mark parity
        s = 31'h3400_0004;
        start_write(s, 8'h1F);
        expect_frame(s, 8'h1F, 1'b0);
        check_idle();
        s = 31'h3700_0004;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            start_write(s, d);
            expect_frame(s, d, 1'b0);
            check_idle();
        end

        // Back-to-back with i_wr held
        s = 31'd4;
        start_write(s, 8'hA5);
        i_wr   = 1'b1;
        i_data = 8'h3C;
        expect_frame(s, 8'hA5, 1'b1);
        i_wr = 1'b0;
        expect_frame(s, 8'h3C, 1'b0);
        check_idle();

        // Break raised mid-frame: frame completes, then 100*B low, then guard
        s = 31'd4;
        start_write(s, 8'h96);
        tick();
        i_break = 1'b1;
        i_wr    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("brk_frame_busy", o_busy, 1'b1);
            tick();
        end
        i_wr = 1'b0;
        build_frame(s, 8'h96);
        for (int i = 0; i < exp_q.size() * 4 - 4; i++) begin
            check("brk_frame_tx", o_uart_tx, exp_q[(i + 4) / 4]);
            tick();
        end
        for (int k = 0; k < 400; k++) begin
            check("brk_tx", o_uart_tx, 1'b0);
            check("brk_busy", o_busy, 1'b1);
            if (k == 399) i_break = 1'b0;
            tick();
        end
        check_guard(4);
        check_idle();

        // Simultaneous write and break at idle: break wins, new B used for guard
        i_setup = 31'd3;
        i_data  = 8'h00;
        i_wr    = 1'b1;
        i_break = 1'b1;
        tick();
        i_wr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check("ibrk_tx", o_uart_tx, 1'b0);
            check("ibrk_busy", o_busy, 1'b1);
            if (k == 19) i_break = 1'b0;
            tick();
        end
        check_guard(3);
        check_idle();

        // Reset during data bits
        s = 31'd5;
        start_write(s, 8'h00);
        for (int k = 0; k < 12; k++) begin
            check("pre_rst_tx", o_uart_tx, 1'b0);
            tick();
        end
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        check_guard(8);
        check_idle();
        s = 31'd6;
        start_write(s, 8'h5A);
        expect_frame(s, 8'h5A, 1'b0);
        check_idle();

`ifdef TXUART_HWFLOW_EN
        // CTS deasserted: write held off until CTS falls
        i_cts_n = 1'b1;
        tick();
        check("cts_busy", o_busy, 1'b1);
        s = 31'd4;
        i_setup = s;
        i_data  = 8'hC7;
        i_wr    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("cts_hold_tx", o_uart_tx, 1'b1);
            check("cts_hold_busy", o_busy, 1'b1);
            tick();
        end
        i_cts_n = 1'b0;
        tick();
        i_wr = 1'b0;
        expect_frame(s, 8'hC7, 1'b1);
        check_idle();
`else
        // Without flow control CTS has no effect
        s = 31'd4;
        i_cts_n = 1'b1;
        i_setup = s;
        i_data  = 8'hC7;
        i_wr    = 1'b1;
        tick();
        i_wr = 1'b0;
        expect_frame(s, 8'hC7, 1'b1);
        check_idle();
        i_cts_n = 1'b0;
`endif

        // Randomized frames, some chained back-to-back
        for (int it = 0; it < 40; it++) begin
            s = rand_setup();
            d = 8'($urandom);
            start_write(s, d);
            if ($urandom_range(0, 2) == 0) begin
                s2 = rand_setup();
                d2 = 8'($urandom);
                i_wr    = 1'b1;
                i_setup = s2;
                i_data  = d2;
                expect_frame(s, d, 1'b1);
                i_wr = 1'b0;
                expect_frame(s2, d2, 1'b0);
            end else begin
                expect_frame(s, d, 1'b0);
            end
            check_idle();
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                tick();
                check_idle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
